// File: rtl/sym_fir_mac.sv
// Symmetric FIR engine: snapshots the tap line, pre-adds mirrored taps
// and accumulates one output over TAPS/2 cycles on a shared multiplier.
module sym_fir_mac #(
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int TAPS = 8,
  parameter int OW   = DW + CW + 1 + $clog2(TAPS / 2)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [TAPS*DW-1:0]          taps_flat,
  input  logic                        tap_valid,
  input  logic [(TAPS/2)*CW-1:0]      coef_flat,
  output logic signed [OW-1:0]        y,
  output logic                        y_valid,
  output logic                        busy,
  output logic                        overrun
);

  localparam int HALF = TAPS / 2;
  localparam int KW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PW   = DW + CW + 1;

  generate
    if ((TAPS % 2) != 0 || TAPS < 2) begin : g_bad_taps
      $error("sym_fir_mac: TAPS must be even and >= 2");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    MAC
  } state_t;

  state_t                 state;
  logic [KW-1:0]          k;
  logic signed [OW-1:0]   acc;
  logic signed [DW-1:0]   snap [TAPS];

  logic signed [DW-1:0]   tap_a;
  logic signed [DW-1:0]   tap_b;
  logic signed [CW-1:0]   coef_k;
  logic signed [DW:0]     pre;
  logic signed [PW-1:0]   prod;
  logic signed [OW-1:0]   sum;
  logic                   last;

  // Mirrored pair and coefficient for the current step
  always_comb begin
    tap_a  = '0;
    tap_b  = '0;
    coef_k = '0;
    for (int i = 0; i < HALF; i++) begin
      if (k == KW'(i)) begin
        tap_a  = snap[i];
        tap_b  = snap[TAPS-1-i];
        coef_k = coef_flat[i*CW +: CW];
      end
    end
  end

  always_comb begin
    pre  = {tap_a[DW-1], tap_a} + {tap_b[DW-1], tap_b};
    prod = pre * coef_k;
    sum  = acc + OW'(prod);
    last = (k == KW'(HALF - 1));
  end

  assign busy = (state == MAC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      acc     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        snap[i] <= '0;
      end
    end else begin
      y_valid <= 1'b0;
      if (tap_valid && state == MAC) begin
        overrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (tap_valid) begin
            for (int i = 0; i < TAPS; i++) begin
              snap[i] <= taps_flat[i*DW +: DW];
            end
            acc   <= '0;
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (last) begin
            y       <= sum;
            y_valid <= 1'b1;
            acc     <= '0;
            k       <= '0;
            state   <= IDLE;
          end else begin
            acc <= sum;
            k   <= k + KW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sym_fir_mac.sv
// Directed bench for sym_fir_mac: vector table plus
// overrun, throughput and mid-MAC reset sequences.
module tb_sym_fir_mac;

  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int TAPS = 8;
  localparam int OW   = DW + CW + 1 + $clog2(TAPS / 2);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [TAPS*DW-1:0]     taps_flat = '0;
  logic                   tap_valid = 1'b0;
  logic [(TAPS/2)*CW-1:0] coef_flat = '0;
  logic signed [OW-1:0]   y;
  logic                   y_valid;
  logic                   busy;
  logic                   overrun;

  sym_fir_mac #(
    .DW(DW), .CW(CW), .TAPS(TAPS), .OW(OW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .taps_flat(taps_flat),
    .tap_valid(tap_valid),
    .coef_flat(coef_flat),
    .y(y),
    .y_valid(y_valid),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] taps;
    logic [31:0] coef;
    longint      exp;
  } vec_t;

  vec_t vecs [6];
  int   checks = 0;
  int   errors = 0;
  int   yv_cnt = 0;

  function automatic logic [63:0] p8(input int a0, a1, a2, a3,
                                     a4, a5, a6, a7);
    return {8'(a7), 8'(a6), 8'(a5), 8'(a4),
            8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [31:0] p4(input int c0, c1, c2, c3);
    return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (y_valid) yv_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tap_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic strobe();
    tap_valid = 1'b1;
    step();
    tap_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int     bc;
    int     lat;
    longint yv;
    taps_flat = v.taps;
    coef_flat = v.coef;
    yv_cnt = 0;
    strobe();
    taps_flat = ~v.taps;
    bc  = busy ? 1 : 0;
    lat = 0;
    yv  = 0;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (busy) bc++;
      if (y_valid && lat == 0) begin
        lat = n;
        yv  = longint'(y);
      end
    end
    chk({v.name, " latency"}, lat, 4);
    chk({v.name, " y"}, yv, v.exp);
    chk({v.name, " busy cycles"}, bc, 4);
    chk({v.name, " pulses"}, yv_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"unit", p8(1,1,1,1,1,1,1,1), p4(1,1,1,1), 8};
    vecs[1] = '{"mirror", p8(1,2,3,4,5,6,7,8), p4(1,2,3,4), 90};
    vecs[2] = '{"negneg", p8(-128,-128,-128,-128,-128,-128,-128,-128),
                p4(-128,-128,-128,-128), 131072};
    vecs[3] = '{"posneg", p8(127,127,127,127,127,127,127,127),
                p4(-128,-128,-128,-128), -130048};
    vecs[4] = '{"mixed", p8(10,-20,30,-40,5,6,7,8), p4(2,-3,4,-5), 394};
    vecs[5] = '{"alt", p8(-1,2,-3,4,-5,6,-7,8), p4(127,-1,0,1), 893};

    do_reset();
    for (int i = 0; i < 20; i++) begin
      chk("idle", longint'({y, y_valid, busy, overrun}), 0);
    end

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end
    chk("vectors overrun", overrun, 0);

    // Second strobe two cycles into a computation
    do_reset();
    taps_flat = vecs[1].taps;
    coef_flat = vecs[1].coef;
    yv_cnt = 0;
    strobe();
    step();
    chk("ovr early", overrun, 0);
    strobe();
    chk("ovr set", overrun, 1);
    for (int i = 0; i < 10; i++) step();
    chk("ovr results", yv_cnt, 1);
    chk("ovr y", longint'(y), 90);
    chk("ovr sticky", overrun, 1);

    // Spacing of 5 cycles sustains full throughput
    do_reset();
    yv_cnt = 0;
    for (int s = 0; s < 4; s++) begin
      strobe();
      for (int i = 0; i < 4; i++) step();
    end
    for (int i = 0; i < 4; i++) step();
    chk("tp5 results", yv_cnt, 4);
    chk("tp5 overrun", overrun, 0);

    // Spacing of 4 hits the final MAC edge every other strobe
    do_reset();
    yv_cnt = 0;
    strobe();
    for (int i = 0; i < 3; i++) step();
    chk("tp4 first", overrun, 0);
    strobe();
    chk("tp4 second", overrun, 1);
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 3; i++) step();
      strobe();
    end
    for (int i = 0; i < 6; i++) step();
    chk("tp4 results", yv_cnt, 3);

    // Held strobe: one acceptance then overruns
    do_reset();
    yv_cnt = 0;
    tap_valid = 1'b1;
    step();
    step();
    step();
    tap_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("held results", yv_cnt, 1);
    chk("held overrun", overrun, 1);

    // Reset two cycles after the strobe discards the result
    do_reset();
    taps_flat = vecs[1].taps;
    coef_flat = vecs[1].coef;
    yv_cnt = 0;
    strobe();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rst async busy", busy, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("rst no pulse", yv_cnt, 0);
    chk("rst y", longint'(y), 0);
    run_vec(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sym_fir_mac.md
# sym_fir_mac

Symmetric-FIR multiply-accumulate engine that sits directly downstream of `shiftreg`, the tap delay line. On each `tap_valid` strobe it snapshots the parallel taps and folds mirrored tap pairs through a pre-adder. It then computes one full-precision filter output over TAPS/2 cycles using a single shared multiplier. A one-cycle `y_valid` strobe presents the result.

## Interface
- `DW`, 8: sample (tap) width, signed two's complement.
- `CW`, 8: coefficient width, signed two's complement.
- `TAPS`, 8: filter length. Must be even and ≥ 2; elaboration error otherwise.
- `OW`, DW+CW+1+$clog2(TAPS/2): output width (19 at defaults). Full precision, no saturation or rounding.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `taps_flat`  in  TAPS*DW: tap[i] = taps_flat[i*DW +: DW]. tap[0] is the newest sample.
- `tap_valid`  in  1: single-cycle strobe; the taps hold a new sample.
- `coef_flat`  in  (TAPS/2)*CW: coef[k] = coef_flat[k*CW +: CW]. Must be held stable while `busy`=1.
- `y`  out  OW: filter output, signed. Holds its value until the next result.
- `y_valid`  out  1: one-cycle strobe; `y` is new.
- `busy`  out  1: high while a computation is in progress.
- `overrun`  out  1: sticky flag. Set when `tap_valid` arrives while busy; cleared only by `rst`.

## Operation
- States: IDLE, MAC. `busy` = (state == MAC).
- IDLE with `tap_valid`=1:
  - Snapshot all TAPS taps into internal registers.
  - Clear the accumulator; set k=0.
  - Go to MAC.
- IDLE with `tap_valid`=0: hold. `y` is unchanged.
- MAC, each cycle, using snapshot taps and current coef:
  - pre = sext(tap[k]) + sext(tap[TAPS-1-k]), DW+1 bits.
  - prod = pre * coef[k], DW+CW+1 bits, signed.
  - If k < TAPS/2-1: acc += sext(prod); k++.
  - If k == TAPS/2-1: y <= acc + sext(prod); y_valid <= 1; acc cleared; state <= IDLE.
- Arithmetic: all additions sign-extended to OW. OW guarantees no overflow for any inputs.
- `tap_valid` while busy (including the final MAC cycle):
  - Sample is dropped; `overrun` <= 1.
  - The in-progress computation is unaffected.
- Taps are snapshotted, so `taps_flat` may change freely after the accepting edge.
- Reset, asserted at any time including mid-MAC:
  - Immediately (asynchronously) forces state=IDLE, k=0, acc=0, snapshot=0.
  - Forces y=0, y_valid=0, busy=0, overrun=0.
  - Any partial result is discarded and never presented.

## Timing
- Edge E0 samples `tap_valid`=1 in IDLE. `busy`=1 after E0.
- Edges E1..E(TAPS/2) perform MAC steps k=0..TAPS/2-1.
- After E(TAPS/2): `y` is valid, `y_valid`=1 for exactly one cycle, `busy`=0.
- Latency: TAPS/2 cycles from the accepting edge to `y_valid` (4 at defaults).
- Minimum accepted `tap_valid` spacing is TAPS/2+1 cycles (5 at defaults). A strobe sampled at E(TAPS/2+1) is accepted.
- A strobe held high for several cycles counts as:
  - one acceptance on the first IDLE-sampled edge;
  - overruns on the following edges that sample it while busy.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then idle: after `rst` deasserts with no strobe, y=0, y_valid=0, busy=0, overrun=0 for 20 cycles.
- Unit check: all taps=1, all coef=1, one strobe → y_valid exactly 4 cycles later, y=8. `busy` is high for exactly 4 cycles.
- Mirrored sum: taps[0..7]=1..8, coef[0..3]=1,2,3,4 → y=90. Then change taps immediately after the strobe → y is still 90.
- Signed extremes:
  - taps all -128, coef all -128 → y=131072.
  - taps all 127, coef all -128 → y=-130048.
- Overrun and throughput:
  - Strobe at cycles 0 and 2 → one result; overrun=1 and stays set.
  - Strobes every 5 cycles → every sample produces a result, overrun stays 0.
  - Strobes every 4 cycles → every second strobe sets overrun.
- Reset mid-MAC: assert `rst` 2 cycles after the strobe → y_valid never pulses and y=0. A fresh strobe after release computes correctly (y=90 with the mirrored-sum vectors).
